// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch sequencer: state encoding,
// default parameters and the per-slot program start addresses.
package fetch_pkg;

    localparam int D_DEF     = 12;
    localparam int NPROG_DEF = 4;
    localparam int LW_DEF    = 6;
    localparam int CW_DEF    = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Slot 2 sits just below a 256-word boundary so narrow builds start near the top.
    localparam logic [D_DEF-1:0] START_ADDR [NPROG_DEF] = '{12'h000, 12'h040, 12'h0FE, 12'h0C0};

    function automatic logic [D_DEF-1:0] start_addr(input int unsigned slot);
        logic [D_DEF-1:0] a;
        a = '0;
        case (slot)
            0:       a = START_ADDR[0];
            1:       a = START_ADDR[1];
            2:       a = START_ADDR[2];
            3:       a = START_ADDR[3];
            default: a = '0;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/fetch_seq_target_lut.sv
// Branch/jump target table: maps an instruction target index to a fetch address.
// Latency: combinational.
// Backpressure: none, pure lookup.
module target_lut #(
    parameter int LW = 6,
    parameter int D  = 12
) (
    input  logic [LW-1:0] idx,
    output logic [D-1:0]  addr
);

    // Entries are written full width; the cast trims or zero-extends to D bits.
    always_comb begin
        addr = '0;
        case (32'(idx))
            32'd0:   addr = D'(32'h0000_0000);
            32'd1:   addr = D'(32'h0000_0010);
            32'd2:   addr = D'(32'h0000_0020);
            32'd3:   addr = D'(32'h0000_0030);
            32'd4:   addr = D'(32'h0000_0080);
            32'd5:   addr = D'(32'h0000_0100);
            32'd6:   addr = D'(32'h0000_0FFF);
            32'd7:   addr = D'(32'h0000_0123);
            32'd8:   addr = D'(32'h0001_0ABC);
            default: addr = '0;
        endcase
    end

endmodule

// File: rtl/fetch_seq.sv
// Program counter sequencer: start on req, step/jump/branch per instruction, stop on halt or PC top.
// Latency: one cycle from accepted req to first fetch; done decoded from state.
// Backpressure: stall freezes PC and count; done held until req is released.
module fetch_seq
    import fetch_pkg::*;
#(
    parameter int D     = D_DEF,
    parameter int NPROG = NPROG_DEF,
    parameter int LW    = LW_DEF,
    parameter int CW    = CW_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req,
    input  logic [$clog2(NPROG)-1:0] prog_sel,
    input  logic                     stall,
    input  logic                     halt,
    input  logic                     jump_en,
    input  logic                     branch_en,
    input  logic                     taken,
    input  logic [LW-1:0]            tgt_idx,
    output logic [D-1:0]             prog_ctr,
    output logic                     fetch_valid,
    output logic                     busy,
    output logic                     done,
    output logic                     ovf,
    output logic [CW-1:0]            instr_cnt
);

    state_t      state;
    state_t      state_nxt;
    logic [D-1:0] lut_addr;
    logic        redirect;
    logic        pc_at_max;
    int unsigned sel_slot;

    target_lut #(.LW(LW), .D(D)) u_lut (
        .idx  (tgt_idx),
        .addr (lut_addr)
    );

    assign redirect  = jump_en || (branch_en && taken);
    assign pc_at_max = (prog_ctr == {D{1'b1}});

    always_comb begin
        sel_slot = 0;
        if (32'(prog_sel) < 32'(NPROG))
            sel_slot = 32'(prog_sel);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: if (req) state_nxt = ST_RUN;
            ST_RUN:  if (!stall && (halt || (!redirect && pc_at_max))) state_nxt = ST_DONE;
            ST_DONE: if (!req) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // fetch_valid is the one output that follows stall within the cycle.
    always_comb begin
        busy        = 1'b0;
        done        = 1'b0;
        fetch_valid = 1'b0;
        case (state)
            ST_RUN: begin
                busy        = 1'b1;
                fetch_valid = !stall;
            end
            ST_DONE: done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prog_ctr  <= '0;
            instr_cnt <= '0;
            ovf       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (req) begin
                    prog_ctr  <= D'(start_addr(sel_slot));
                    instr_cnt <= '0;
                    ovf       <= 1'b0;
                end
                ST_RUN: if (!stall) begin
                    if (instr_cnt != {CW{1'b1}})
                        instr_cnt <= instr_cnt + CW'(1);
                    if (!halt) begin
                        if (redirect)
                            prog_ctr <= lut_addr;
                        else if (pc_at_max)
                            ovf <= 1'b1;
                        else
                            prog_ctr <= prog_ctr + D'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_seq.sv
// Directed bench: a vector table on the default build plus hand sequences on a
// narrow build (D=4, NPROG=3, CW=2) for wrap, slot fallback and count saturation.
module tb_fetch_seq;

    localparam logic [4:0] C_ST = 5'b10000;
    localparam logic [4:0] C_H  = 5'b01000;
    localparam logic [4:0] C_J  = 5'b00100;
    localparam logic [4:0] C_B  = 5'b00010;
    localparam logic [4:0] C_T  = 5'b00001;

    // {busy, done, ovf}
    localparam logic [2:0] O_IDLE  = 3'b000;
    localparam logic [2:0] O_IDLEV = 3'b001;
    localparam logic [2:0] O_RUN   = 3'b100;
    localparam logic [2:0] O_DONE  = 3'b010;
    localparam logic [2:0] O_DONEV = 3'b011;

    logic        clk = 1'b0;
    logic        reset, req, s_req, stall, halt, jump_en, branch_en, taken;
    logic [1:0]  prog_sel;
    logic [5:0]  tgt_idx;
    logic [11:0] prog_ctr;
    logic        fetch_valid, busy, done, ovf;
    logic [15:0] instr_cnt;
    logic [3:0]  s_pc;
    logic        s_fv, s_busy, s_done, s_ovf;
    logic [1:0]  s_cnt;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic        req;
        logic [1:0]  sel;
        logic [4:0]  ctl;
        logic [5:0]  tgt;
        logic [11:0] pc;
        logic [15:0] cnt;
        logic [2:0]  st;
        logic        fv;
    } vec_t;

    vec_t vt [26];

    always #5 clk = ~clk;

    fetch_seq u_dut (
        .clk(clk), .reset(reset), .req(req), .prog_sel(prog_sel), .stall(stall),
        .halt(halt), .jump_en(jump_en), .branch_en(branch_en), .taken(taken),
        .tgt_idx(tgt_idx), .prog_ctr(prog_ctr), .fetch_valid(fetch_valid),
        .busy(busy), .done(done), .ovf(ovf), .instr_cnt(instr_cnt)
    );

    fetch_seq #(.D(4), .NPROG(3), .LW(6), .CW(2)) u_small (
        .clk(clk), .reset(reset), .req(s_req), .prog_sel(prog_sel), .stall(stall),
        .halt(halt), .jump_en(jump_en), .branch_en(branch_en), .taken(taken),
        .tgt_idx(tgt_idx), .prog_ctr(s_pc), .fetch_valid(s_fv),
        .busy(s_busy), .done(s_done), .ovf(s_ovf), .instr_cnt(s_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_ctl(input logic [4:0] c);
        {stall, halt, jump_en, branch_en, taken} = c;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_main(input string tag, input logic [11:0] pc, input logic [15:0] cnt,
                              input logic [2:0] st, input logic fv);
        check({tag, ".pc"},   32'(prog_ctr), 32'(pc));
        check({tag, ".cnt"},  32'(instr_cnt), 32'(cnt));
        check({tag, ".bdo"},  32'({busy, done, ovf}), 32'(st));
        check({tag, ".fv"},   32'(fetch_valid), 32'(fv));
    endtask

    task automatic check_small(input string tag, input logic [3:0] pc, input logic [1:0] cnt,
                               input logic [2:0] st, input logic fv);
        check({tag, ".pc"},  32'(s_pc), 32'(pc));
        check({tag, ".cnt"}, 32'(s_cnt), 32'(cnt));
        check({tag, ".bdo"}, 32'({s_busy, s_done, s_ovf}), 32'(st));
        check({tag, ".fv"},  32'(s_fv), 32'(fv));
    endtask

    initial begin
        // req, sel, ctl, tgt, pc, cnt, {busy,done,ovf}, fv  -- outputs after the edge
        vt[0]  = '{1'b1, 2'd1, 5'b0,            6'd0, 12'h040, 16'd0, O_RUN,   1'b1};
        vt[1]  = '{1'b1, 2'd1, 5'b0,            6'd0, 12'h041, 16'd1, O_RUN,   1'b1};
        vt[2]  = '{1'b0, 2'd0, 5'b0,            6'd0, 12'h042, 16'd2, O_RUN,   1'b1};
        vt[3]  = '{1'b0, 2'd0, 5'b0,            6'd0, 12'h043, 16'd3, O_RUN,   1'b1};
        vt[4]  = '{1'b1, 2'd0, C_H,             6'd0, 12'h043, 16'd4, O_DONE,  1'b0};
        vt[5]  = '{1'b1, 2'd0, 5'b0,            6'd0, 12'h043, 16'd4, O_DONE,  1'b0};
        vt[6]  = '{1'b0, 2'd0, 5'b0,            6'd0, 12'h043, 16'd4, O_IDLE,  1'b0};
        vt[7]  = '{1'b1, 2'd0, 5'b0,            6'd0, 12'h000, 16'd0, O_RUN,   1'b1};
        vt[8]  = '{1'b0, 2'd0, C_J|C_B|C_T,     6'd5, 12'h100, 16'd1, O_RUN,   1'b1};
        vt[9]  = '{1'b1, 2'd0, C_H|C_J|C_B|C_T, 6'd5, 12'h100, 16'd2, O_DONE,  1'b0};
        vt[10] = '{1'b0, 2'd0, 5'b0,            6'd0, 12'h100, 16'd2, O_IDLE,  1'b0};
        vt[11] = '{1'b1, 2'd2, 5'b0,            6'd0, 12'h0FE, 16'd0, O_RUN,   1'b1};
        vt[12] = '{1'b0, 2'd0, C_B,             6'd5, 12'h0FF, 16'd1, O_RUN,   1'b1};
        vt[13] = '{1'b0, 2'd0, C_B|C_T,         6'd2, 12'h020, 16'd2, O_RUN,   1'b1};
        vt[14] = '{1'b0, 2'd0, C_ST|C_J,        6'd5, 12'h020, 16'd2, O_RUN,   1'b0};
        vt[15] = '{1'b0, 2'd0, C_ST|C_H,        6'd0, 12'h020, 16'd2, O_RUN,   1'b0};
        vt[16] = '{1'b0, 2'd0, C_ST,            6'd0, 12'h020, 16'd2, O_RUN,   1'b0};
        vt[17] = '{1'b0, 2'd0, 5'b0,            6'd0, 12'h021, 16'd3, O_RUN,   1'b1};
        vt[18] = '{1'b0, 2'd0, C_J,             6'd6, 12'hFFF, 16'd4, O_RUN,   1'b1};
        vt[19] = '{1'b0, 2'd0, 5'b0,            6'd0, 12'hFFF, 16'd5, O_DONEV, 1'b0};
        vt[20] = '{1'b0, 2'd0, 5'b0,            6'd0, 12'hFFF, 16'd5, O_IDLEV, 1'b0};
        vt[21] = '{1'b1, 2'd3, 5'b0,            6'd0, 12'h0C0, 16'd0, O_RUN,   1'b1};
        vt[22] = '{1'b0, 2'd0, C_J,             6'd8, 12'hABC, 16'd1, O_RUN,   1'b1};
        vt[23] = '{1'b0, 2'd0, C_B|C_T,         6'd7, 12'h123, 16'd2, O_RUN,   1'b1};
        vt[24] = '{1'b0, 2'd0, C_H,             6'd0, 12'h123, 16'd3, O_DONE,  1'b0};
        vt[25] = '{1'b0, 2'd0, 5'b0,            6'd0, 12'h123, 16'd3, O_IDLE,  1'b0};

        reset = 1'b1; req = 1'b0; s_req = 1'b0; prog_sel = 2'd0; tgt_idx = 6'd0;
        set_ctl(5'b0);
        #1 reset = 1'b0;
        #1 check_main("rst_async", 12'h000, 16'd0, O_IDLE, 1'b0);
        check_small("rst_async_s", 4'h0, 2'd0, O_IDLE, 1'b0);
        tick();
        tick();
        check_main("rst_held", 12'h000, 16'd0, O_IDLE, 1'b0);
        @(negedge clk) reset = 1'b1;
        tick();
        check_main("post_rst", 12'h000, 16'd0, O_IDLE, 1'b0);

        for (int i = 0; i < 26; i++) begin
            @(negedge clk);
            req      = vt[i].req;
            prog_sel = vt[i].sel;
            tgt_idx  = vt[i].tgt;
            set_ctl(vt[i].ctl);
            tick();
            check_main($sformatf("v%0d", i), vt[i].pc, vt[i].cnt, vt[i].st, vt[i].fv);
        end

        // Narrow build: PC runs off the top and stops with ovf.
        @(negedge clk) s_req = 1'b1; prog_sel = 2'd2; set_ctl(5'b0);
        tick(); check_small("wrap0", 4'hE, 2'd0, O_RUN, 1'b1);
        @(negedge clk) s_req = 1'b0;
        tick(); check_small("wrap1", 4'hF, 2'd1, O_RUN, 1'b1);
        tick(); check_small("wrap2", 4'hF, 2'd2, O_DONEV, 1'b0);
        tick(); check_small("wrap3", 4'hF, 2'd2, O_IDLEV, 1'b0);
        check("wrap_main_idle", 32'(busy), 32'd0);

        // Out-of-range slot falls back to slot 0; count saturates at 3.
        @(negedge clk) s_req = 1'b1; prog_sel = 2'd3;
        tick(); check_small("slot_fb", 4'h0, 2'd0, O_RUN, 1'b1);
        @(negedge clk) s_req = 1'b0;
        tick(); check_small("sat1", 4'h1, 2'd1, O_RUN, 1'b1);
        tick(); check_small("sat2", 4'h2, 2'd2, O_RUN, 1'b1);
        tick(); check_small("sat3", 4'h3, 2'd3, O_RUN, 1'b1);
        tick(); check_small("sat4", 4'h4, 2'd3, O_RUN, 1'b1);
        @(negedge clk) set_ctl(C_H);
        tick(); check_small("sat_halt", 4'h4, 2'd3, O_DONE, 1'b0);
        @(negedge clk) set_ctl(5'b0);
        tick(); check_small("sat_idle", 4'h4, 2'd3, O_IDLE, 1'b0);

        // Asynchronous reset in the middle of a run.
        @(negedge clk) req = 1'b1; prog_sel = 2'd1;
        tick(); check_main("ar_start", 12'h040, 16'd0, O_RUN, 1'b1);
        @(negedge clk) req = 1'b0;
        tick(); check_main("ar_step", 12'h041, 16'd1, O_RUN, 1'b1);
        @(negedge clk);
        #2 reset = 1'b0;
        #1 check_main("ar_now", 12'h000, 16'd0, O_IDLE, 1'b0);
        tick();
        @(negedge clk) reset = 1'b1;
        tick(); tick(); tick();
        check_main("ar_wait", 12'h000, 16'd0, O_IDLE, 1'b0);
        @(negedge clk) req = 1'b1; prog_sel = 2'd1;
        tick(); check_main("ar_restart", 12'h040, 16'd0, O_RUN, 1'b1);
        @(negedge clk) set_ctl(C_H); req = 1'b0;
        tick(); check_main("ar_halt", 12'h040, 16'd1, O_DONE, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
